// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM state encoding and the common frame width.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LAST  = 2'd2
  } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI line plus one-clk rise/fall strobes.
// RESET_VAL is the line's idle level, so that releasing reset never fakes an edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   level_s;

  assign level_s = sync_q[SYNC_STAGES-1];

  // Shift the raw line through the synchroniser and keep one delayed copy for edge detection
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = level_s;
  end

  // Synchroniser and edge-history flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = level_s & ~prev_q;
  assign fall = ~level_s & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: one-entry staging register fed by valid/ready,
// MSB-first shift-out on miso while cs is low, done/underrun status pulses.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              miso,
  output logic              miso_oe,
  output logic              done,
  output logic              underrun
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_slv_state_e    state_q, state_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic              stage_full_q, stage_full_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              fresh_q, fresh_d;
  logic              pend_ur_q, pend_ur_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] load_word;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign load_word = stage_full_q ? stage_q : IDLE_WORD;

  // Next-state logic: staging handshake, frame load, bit counting and shifting.
  // A reload in LAST with nothing staged only flags the underrun; it is reported on the
  // first sclk rise of that word, so a frame that simply ends after its last word is not
  // counted as an underrun.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    fresh_d      = fresh_q;
    pend_ur_d    = pend_ur_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;

    if (tx_valid && !stage_full_q) begin
      stage_d      = tx_data;
      stage_full_d = 1'b1;
    end

    if (cs_rise) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      bitcnt_d  = '0;
      fresh_d   = 1'b0;
      pend_ur_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          if (cs_fall) begin
            shreg_d   = load_word;
            miso_d    = load_word[DATA_W-1];
            miso_oe_d = 1'b1;
            bitcnt_d  = '0;
            fresh_d   = 1'b0;
            if (stage_full_q) stage_full_d = 1'b0;
            else              underrun_d   = 1'b1;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          miso_oe_d = 1'b1;
          if (sclk_rise) begin
            bitcnt_d = bitcnt_q + 1'b1;
            if (pend_ur_q) begin
              underrun_d = 1'b1;
              pend_ur_d  = 1'b0;
            end
            if (bitcnt_q == LAST_CNT) state_d = LAST;
          end else if (sclk_fall) begin
            if (fresh_q) begin
              miso_d  = shreg_q[DATA_W-1];
              fresh_d = 1'b0;
            end else begin
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
              miso_d  = shreg_q[DATA_W-2];
            end
          end
        end
        LAST: begin
          miso_oe_d = 1'b1;
          done_d    = 1'b1;
          shreg_d   = load_word;
          bitcnt_d  = '0;
          fresh_d   = 1'b1;
          if (stage_full_q) stage_full_d = 1'b0;
          else              pend_ur_d    = 1'b1;
          state_d   = SHIFT;
        end
        default: begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      fresh_q      <= 1'b0;
      pend_ur_q    <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      fresh_q      <= fresh_d;
      pend_ur_q    <= pend_ur_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign tx_ready = ~stage_full_q;
  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: a mode-0 master model (clk period 10, sclk period 200)
// shifts words out of the slave; staged words are queued as expected results and
// popped whenever the master has assembled a full word.
module tb_spi_slave_tx;
  import spi_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, miso, miso_oe, done, underrun;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_byte = 8'h00;
  int         rx_bits = 0;

  int   done_cnt = 0;
  int   wide_cnt = 0;
  int   ur_cnt = 0;
  logic done_prev = 1'b0;
  logic ur_prev = 1'b0;

  spi_slave_tx #(.DATA_W(SPI_DATA_W), .SYNC_STAGES(SYNC_STAGES), .IDLE_WORD(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .done     (done),
    .underrun (underrun)
  );

  // System clock, period 10
  initial forever #5 clk = ~clk;

  // Count done/underrun pulses and flag any done pulse wider than one clk
  always @(negedge clk) begin
    if (done && !done_prev) done_cnt <= done_cnt + 1;
    if (done && done_prev)  wide_cnt <= wide_cnt + 1;
    if (underrun && !ur_prev) ur_cnt <= ur_cnt + 1;
    done_prev <= done;
    ur_prev   <= underrun;
  end

  // Offer a word to the stage; queue it as expected output when it will be transmitted
  task automatic stage_word(input logic [7:0] w, input bit expect_tx);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        tx_data  = w;
        tx_valid = 1'b1;
        ok       = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL stage_handshake: tx_ready never high within 50 clk, word %h", w);
    end else if (expect_tx) begin
      exp_q.push_back(w);
    end
  endtask

  // Master drops cs and waits well past the slave's load latency
  task automatic cs_low();
    @(negedge clk);
    cs      = 1'b0;
    rx_bits = 0;
    rx_byte = 8'h00;
    #100;
  endtask

  // Master clocks n bits, sampling miso at each rising sclk edge
  task automatic clock_bits(input int n);
    logic       b;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      b       = miso;
      sclk    = 1'b1;
      rx_byte = {rx_byte[6:0], b};
      rx_bits++;
      if (rx_bits % 8 == 0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL rx_word: got %h, scoreboard empty", rx_byte);
        end else begin
          e = exp_q.pop_front();
          if (rx_byte !== e) begin
            bad++;
            $display("[TB] FAIL rx_word: got %h expected %h", rx_byte, e);
          end
        end
      end
      #100;
      sclk = 1'b0;
      #100;
    end
  endtask

  task automatic cs_high();
    cs = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({tx_ready, miso, miso_oe, done, underrun} !== 5'b10000) begin
        bad++;
        $display("[TB] FAIL reset_outputs: ready/miso/oe/done/ur=%b expected 10000", {tx_ready, miso, miso_oe, done, underrun});
      end
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int d0 = done_cnt;
    stage_word(8'hA5, 1'b1);
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stage_full_ready: tx_ready=%b expected 0", tx_ready);
    end
    cs_low();
    total++;
    if ({tx_ready, miso, miso_oe} !== 3'b111) begin
      bad++;
      $display("[TB] FAIL load_state: ready/miso/oe=%b expected 111", {tx_ready, miso, miso_oe});
    end
    clock_bits(8);
    cs_high();
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("[TB] FAIL single_done: %0d pulses expected 1", done_cnt - d0);
    end
    total++;
    if (wide_cnt !== 0) begin
      bad++;
      $display("[TB] FAIL done_width: %0d extra high cycles expected 0", wide_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int u0 = ur_cnt;
    stage_word(8'h3C, 1'b1);
    cs_low();
    fork
      clock_bits(16);
      begin
        #400;
        stage_word(8'hC3, 1'b1);
      end
    join
    cs_high();
    total++;
    if (done_cnt - d0 !== 2) begin
      bad++;
      $display("[TB] FAIL b2b_done: %0d pulses expected 2", done_cnt - d0);
    end
    total++;
    if (ur_cnt - u0 !== 0) begin
      bad++;
      $display("[TB] FAIL b2b_underrun: %0d pulses expected 0", ur_cnt - u0);
    end
  endtask

  task automatic test_underrun();
    int d0 = done_cnt;
    int u0 = ur_cnt;
    exp_q.push_back(8'hFF);
    cs_low();
    clock_bits(8);
    cs_high();
    total++;
    if (ur_cnt - u0 !== 1) begin
      bad++;
      $display("[TB] FAIL underrun_count: %0d pulses expected 1", ur_cnt - u0);
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("[TB] FAIL underrun_done: %0d pulses expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    bit off = 1'b0;
    stage_word(8'h81, 1'b0);
    cs_low();
    clock_bits(3);
    @(negedge clk);
    cs = 1'b1;
    for (int i = 0; i < SYNC_STAGES + 2 && !off; i++) begin
      @(negedge clk);
      if (miso_oe === 1'b0 && miso === 1'b0) off = 1'b1;
    end
    total++;
    if (!off) begin
      bad++;
      $display("[TB] FAIL abort_oe: miso_oe=%b miso=%b expected 0 0 within %0d clk", miso_oe, miso, SYNC_STAGES + 2);
    end
    #200;
    total++;
    if (done_cnt - d0 !== 0) begin
      bad++;
      $display("[TB] FAIL abort_done: %0d pulses expected 0", done_cnt - d0);
    end
    // sclk activity with cs high must neither start a frame nor consume the stage
    stage_word(8'h7E, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1;
      #100;
      sclk = 1'b0;
      #100;
    end
    total++;
    if ({tx_ready, miso_oe, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL idle_sclk: ready/oe/done=%b expected 000", {tx_ready, miso_oe, done});
    end
    cs_low();
    clock_bits(8);
    cs_high();
  endtask

  task automatic test_async_reset();
    int u0;
    stage_word(8'hF0, 1'b0);
    cs_low();
    stage_word(8'h55, 1'b0);
    clock_bits(3);
    sclk = 1'b1;
    #50;
    total++;
    if ({tx_ready, miso, miso_oe} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL pre_reset: ready/miso/oe=%b expected 011", {tx_ready, miso, miso_oe});
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({tx_ready, miso, miso_oe, done, underrun} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL async_reset: ready/miso/oe/done/ur=%b expected 10000", {tx_ready, miso, miso_oe, done, underrun});
    end
    sclk = 1'b0;
    cs   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    u0 = ur_cnt;
    exp_q.push_back(8'hFF);
    cs_low();
    clock_bits(8);
    cs_high();
    total++;
    if (ur_cnt - u0 !== 1) begin
      bad++;
      $display("[TB] FAIL post_reset_underrun: %0d pulses expected 1", ur_cnt - u0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_async_reset();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: %0d words left expected 0", exp_q.size());
    end
    total++;
    if (wide_cnt !== 0) begin
      bad++;
      $display("[TB] FAIL done_width_final: %0d extra high cycles expected 0", wide_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
